uart_host_arbiter: RTL and testbench

UART_HOST_ARBITER -- requirements
Module: uart_host_arbiter

---
 rtl/uart_arbiter_pkg.sv | 14 +
 rtl/uart_host_arbiter_rr_selector.sv | 26 ++
 rtl/uart_host_arbiter.sv | 168 ++++++++++++++++
 tb/tb_uart_host_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_arbiter_pkg.sv
// Shared types and widths for the two-requester UART host bus arbiter.
package uart_arbiter_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_host_arbiter_rr_selector.sv
// Winner select for two requesters: round-robin on a last-served bit, or
// requester 0 always first when UART_ARB_FIXED_PRIORITY_EN is defined.
module rr_selector (
  input  logic [1:0] req_i,
`ifndef UART_ARB_FIXED_PRIORITY_EN
  input  logic       last_i,
`endif
  output logic [1:0] gnt_o
);

  // One-hot winner; on a tie the requester not served last takes the bus
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
`ifdef UART_ARB_FIXED_PRIORITY_EN
      2'b11:   gnt_o = 2'b01;
`else
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
`endif
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/uart_host_arbiter.sv
// Two-requester host arbiter driving a UART register bus with setup/strobe/recover timing.
// Optional macro UART_ARB_FIXED_PRIORITY_EN selects fixed priority (requester 0 wins).
module uart_host_arbiter
  import uart_arbiter_pkg::*;
#(
  parameter int STROBE_CYCLES  = 2,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [1:0]             req_i,
  input  logic [1:0]             we_i,
  input  logic [1:0][ADDR_W-1:0] addr_i,
  input  logic [1:0][DATA_W-1:0] wdata_i,
  output logic [1:0]             gnt_o,
  output logic [1:0]             done_o,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   chip_sel_n_o,
  output logic [ADDR_W-1:0]      address_o,
  output logic                   read_write_o,
  output logic [DATA_W-1:0]      data_o,
  output logic                   data_oe_o,
  input  logic [DATA_W-1:0]      data_i
);

  localparam logic [3:0] STROBE_LAST  = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] RECOVER_LAST = 4'(RECOVER_CYCLES - 1);

  arb_state_e          state_r, state_s;
  logic [3:0]          cnt_r, cnt_s;
  logic                win_r, win_s;
  logic [1:0]          sel_s;
  logic [1:0]          gnt_r, gnt_s;
  logic [1:0]          done_r, done_s;
  logic [DATA_W-1:0]   rdata_r, rdata_s;
  logic                cs_n_r, cs_n_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic                rw_r, rw_s;
  logic [DATA_W-1:0]   data_r, data_s;
  logic                oe_r, oe_s;
`ifndef UART_ARB_FIXED_PRIORITY_EN
  logic                last_r, last_s;
`endif

  rr_selector u_sel (
    .req_i  (req_i),
`ifndef UART_ARB_FIXED_PRIORITY_EN
    .last_i (last_r),
`endif
    .gnt_o  (sel_s)
  );

  // Next-state and next-output decode; every bus output is registered below
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    win_s   = win_r;
    gnt_s   = gnt_r;
    done_s  = 2'b00;
    rdata_s = rdata_r;
    cs_n_s  = cs_n_r;
    addr_s  = addr_r;
    rw_s    = rw_r;
    data_s  = data_r;
    oe_s    = oe_r;
`ifndef UART_ARB_FIXED_PRIORITY_EN
    last_s  = last_r;
`endif
    case (state_r)
      IDLE: begin
        if (sel_s != 2'b00) begin
          win_s   = sel_s[1];
          gnt_s   = sel_s;
          addr_s  = addr_i[sel_s[1]];
          rw_s    = ~we_i[sel_s[1]];
          data_s  = wdata_i[sel_s[1]];
          oe_s    = we_i[sel_s[1]];
          cnt_s   = 4'd0;
          state_s = SETUP;
`ifndef UART_ARB_FIXED_PRIORITY_EN
          last_s  = sel_s[1];
`endif
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        cs_n_s  = 1'b0;
        cnt_s   = 4'd0;
        state_s = STROBE;
      end
      STROBE: begin
        if (cnt_r == STROBE_LAST) begin
          cs_n_s  = 1'b1;
          gnt_s   = 2'b00;
          done_s  = win_r ? 2'b10 : 2'b01;
          rdata_s = rw_r ? data_i : rdata_r;
          cnt_s   = 4'd0;
          state_s = RECOVER;
        end else begin
          cnt_s   = cnt_r + 4'd1;
        end
      end
      RECOVER: begin
        // the enable covers the first recovery cycle as write hold time
        oe_s = 1'b0;
        if (cnt_r == RECOVER_LAST) begin
          cnt_s   = 4'd0;
          state_s = IDLE;
        end else begin
          cnt_s   = cnt_r + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
        cs_n_s  = 1'b1;
        oe_s    = 1'b0;
        gnt_s   = 2'b00;
      end
    endcase
  end

  // State, pointer and output registers; reset aborts any access in flight
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      win_r   <= 1'b0;
      gnt_r   <= 2'b00;
      done_r  <= 2'b00;
      rdata_r <= 8'h00;
      cs_n_r  <= 1'b1;
      addr_r  <= 3'd0;
      rw_r    <= 1'b1;
      data_r  <= 8'h00;
      oe_r    <= 1'b0;
`ifndef UART_ARB_FIXED_PRIORITY_EN
      last_r  <= 1'b1;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      win_r   <= win_s;
      gnt_r   <= gnt_s;
      done_r  <= done_s;
      rdata_r <= rdata_s;
      cs_n_r  <= cs_n_s;
      addr_r  <= addr_s;
      rw_r    <= rw_s;
      data_r  <= data_s;
      oe_r    <= oe_s;
`ifndef UART_ARB_FIXED_PRIORITY_EN
      last_r  <= last_s;
`endif
    end
  end

  assign gnt_o        = gnt_r;
  assign done_o       = done_r;
  assign rdata_o      = rdata_r;
  assign chip_sel_n_o = cs_n_r;
  assign address_o    = addr_r;
  assign read_write_o = rw_r;
  assign data_o       = data_r;
  assign data_oe_o    = oe_r;

endmodule

// File: tb/tb_uart_host_arbiter.sv
// Directed self-checking bench for uart_host_arbiter with default timing parameters.
module tb_uart_host_arbiter;

  localparam int S = 2;
  localparam int R = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req, we;
  logic [1:0][2:0] addr;
  logic [1:0][7:0] wdata;
  logic [1:0]      gnt, done;
  logic [7:0]      rdata, data_out, data_in;
  logic            cs_n, rw, oe;
  logic [2:0]      address;

  int n_cmp = 0;
  int n_bad = 0;
  int fall_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge cs_n) fall_cnt++;

  uart_host_arbiter #(.STROBE_CYCLES(S), .RECOVER_CYCLES(R)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_i        (req),
    .we_i         (we),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .gnt_o        (gnt),
    .done_o       (done),
    .rdata_o      (rdata),
    .chip_sel_n_o (cs_n),
    .address_o    (address),
    .read_write_o (rw),
    .data_o       (data_out),
    .data_oe_o    (oe),
    .data_i       (data_in)
  );

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b00; we = 2'b00; addr = '0; wdata = '0; data_in = 8'hFF;
    @(negedge clk);
    n_cmp++; if (cs_n !== 1'b1)    begin n_bad++; $display("FAIL reset_cs got %b want 1", cs_n); end
    n_cmp++; if (oe !== 1'b0)      begin n_bad++; $display("FAIL reset_oe got %b want 0", oe); end
    n_cmp++; if (gnt !== 2'b00)    begin n_bad++; $display("FAIL reset_gnt got %b want 00", gnt); end
    n_cmp++; if (done !== 2'b00)   begin n_bad++; $display("FAIL reset_done got %b want 00", done); end
    n_cmp++; if (rdata !== 8'h00)  begin n_bad++; $display("FAIL reset_rdata got %h want 00", rdata); end
    n_cmp++; if (address !== 3'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", address); end
    n_cmp++; if (rw !== 1'b1)      begin n_bad++; $display("FAIL reset_rw got %b want 1", rw); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", data_out); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    int f0;
    f0 = fall_cnt;
    req = 2'b01; we = 2'b01; addr[0] = 3'd3; wdata[0] = 8'hA5;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      case (k)
        1: begin
          n_cmp++; if (gnt !== 2'b01)  begin n_bad++; $display("FAIL wr_setup_gnt got %b want 01", gnt); end
          n_cmp++; if (cs_n !== 1'b1)  begin n_bad++; $display("FAIL wr_setup_cs got %b want 1", cs_n); end
          n_cmp++; if (oe !== 1'b1)    begin n_bad++; $display("FAIL wr_setup_oe got %b want 1", oe); end
          n_cmp++; if (address !== 3'd3) begin n_bad++; $display("FAIL wr_setup_addr got %0d want 3", address); end
          n_cmp++; if (rw !== 1'b0)    begin n_bad++; $display("FAIL wr_setup_rw got %b want 0", rw); end
          n_cmp++; if (data_out !== 8'hA5) begin n_bad++; $display("FAIL wr_setup_data got %h want a5", data_out); end
        end
        2, 3: begin
          n_cmp++; if (cs_n !== 1'b0)  begin n_bad++; $display("FAIL wr_strobe_cs k=%0d got %b want 0", k, cs_n); end
          n_cmp++; if (address !== 3'd3 || data_out !== 8'hA5 || rw !== 1'b0)
            begin n_bad++; $display("FAIL wr_strobe_bus k=%0d got %0d/%h/%b want 3/a5/0", k, address, data_out, rw); end
          n_cmp++; if (done !== 2'b00) begin n_bad++; $display("FAIL wr_strobe_done k=%0d got %b want 00", k, done); end
        end
        4: begin
          n_cmp++; if (done !== 2'b01) begin n_bad++; $display("FAIL wr_done got %b want 01", done); end
          n_cmp++; if (cs_n !== 1'b1 || gnt !== 2'b00 || oe !== 1'b1)
            begin n_bad++; $display("FAIL wr_recover got cs=%b gnt=%b oe=%b want 1/00/1", cs_n, gnt, oe); end
          req = 2'b00;
        end
        default: begin
          n_cmp++; if (done !== 2'b00 || oe !== 1'b0)
            begin n_bad++; $display("FAIL wr_after got done=%b oe=%b want 00/0", done, oe); end
        end
      endcase
    end
    n_cmp++; if (fall_cnt - f0 != 1) begin n_bad++; $display("FAIL wr_falls got %0d want 1", fall_cnt - f0); end
  endtask

  task automatic test_single_read();
    logic oe_seen;
    oe_seen = 1'b0;
    req = 2'b10; we = 2'b00; addr[1] = 3'd5;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      oe_seen = oe_seen | oe;
      case (k)
        1: begin
          n_cmp++; if (gnt !== 2'b10 || rw !== 1'b1 || address !== 3'd5)
            begin n_bad++; $display("FAIL rd_setup got gnt=%b rw=%b addr=%0d want 10/1/5", gnt, rw, address); end
          data_in = 8'h3C;
        end
        4: begin
          n_cmp++; if (done !== 2'b10) begin n_bad++; $display("FAIL rd_done got %b want 10", done); end
          n_cmp++; if (rdata !== 8'h3C) begin n_bad++; $display("FAIL rd_rdata got %h want 3c", rdata); end
          req = 2'b00; data_in = 8'h00;
        end
        default: begin
          n_cmp++; if (done !== 2'b00) begin n_bad++; $display("FAIL rd_nodone k=%0d got %b want 00", k, done); end
        end
      endcase
    end
    n_cmp++; if (oe_seen !== 1'b0) begin n_bad++; $display("FAIL rd_oe got %b want 0", oe_seen); end
    @(negedge clk);
    n_cmp++; if (rdata !== 8'h3C) begin n_bad++; $display("FAIL rd_hold got %h want 3c", rdata); end
  endtask

  task automatic test_busy_ignore();
    int f0, d0, d1;
    f0 = fall_cnt; d0 = 0; d1 = 0;
    req = 2'b10; we = 2'b00; addr[1] = 3'd4;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done[0]) d0++;
      if (done[1]) begin d1++; req[1] = 1'b0; end
      if (k == 2) req[0] = 1'b1;
      if (k == 3) req[0] = 1'b0;
    end
    n_cmp++; if (d0 != 0) begin n_bad++; $display("FAIL busy_done0 got %0d want 0", d0); end
    n_cmp++; if (d1 != 1) begin n_bad++; $display("FAIL busy_done1 got %0d want 1", d1); end
    n_cmp++; if (fall_cnt - f0 != 1) begin n_bad++; $display("FAIL busy_falls got %0d want 1", fall_cnt - f0); end
  endtask

  task automatic test_reset_mid_strobe();
    int done_seen, cs_low;
    done_seen = 0; cs_low = 0;
    req = 2'b01; we = 2'b01; addr[0] = 3'd6; wdata[0] = 8'h5A;
    repeat (3) @(negedge clk);
    n_cmp++; if (cs_n !== 1'b0) begin n_bad++; $display("FAIL mid_strobe_cs got %b want 0", cs_n); end
    rst_n = 1'b0; req = 2'b00;
    #1;
    n_cmp++; if (cs_n !== 1'b1 || oe !== 1'b0) begin n_bad++; $display("FAIL mid_rst_bus got cs=%b oe=%b want 1/0", cs_n, oe); end
    n_cmp++; if (gnt !== 2'b00 || done !== 2'b00) begin n_bad++; $display("FAIL mid_rst_hs got gnt=%b done=%b want 00/00", gnt, done); end
    n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL mid_rst_rdata got %h want 00", rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done !== 2'b00) done_seen++;
      if (cs_n !== 1'b1) cs_low++;
    end
    n_cmp++; if (done_seen != 0) begin n_bad++; $display("FAIL mid_rst_nodone got %0d want 0", done_seen); end
    n_cmp++; if (cs_low != 0) begin n_bad++; $display("FAIL mid_rst_idle got %0d want 0", cs_low); end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [4];
    logic [1:0] exp_seq [4];
    int ndone, hi, min_hi, last_cyc, f0;
    ndone = 0; hi = 0; min_hi = 99; last_cyc = 0; f0 = fall_cnt;
`ifdef UART_ARB_FIXED_PRIORITY_EN
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b01;
`else
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
`endif
    we = 2'b11; addr[0] = 3'd1; addr[1] = 3'd2; wdata[0] = 8'h11; wdata[1] = 8'h22;
    req = 2'b11;
    for (int cyc = 1; cyc <= 60 && ndone < 4; cyc++) begin
      @(negedge clk);
      if (cs_n) hi++;
      else begin
        if (ndone > 0 && hi > 0 && hi < min_hi) min_hi = hi;
        hi = 0;
      end
      if (done !== 2'b00) begin
        seq[ndone] = done;
        if (ndone > 0) begin
          n_cmp++; if (cyc - last_cyc != S + R + 2)
            begin n_bad++; $display("FAIL rr_gap got %0d want %0d", cyc - last_cyc, S + R + 2); end
        end
        last_cyc = cyc;
        ndone++;
        if (ndone == 4) req = 2'b00;
      end
    end
    n_cmp++; if (ndone != 4) begin n_bad++; $display("FAIL rr_timeout got %0d want 4 accesses", ndone); end
    for (int i = 0; i < ndone; i++) begin
      n_cmp++; if (seq[i] !== exp_seq[i]) begin n_bad++; $display("FAIL rr_grant%0d got %b want %b", i, seq[i], exp_seq[i]); end
    end
    n_cmp++; if (min_hi != R + 2) begin n_bad++; $display("FAIL rr_cs_high got %0d want %0d", min_hi, R + 2); end
    repeat (3) @(negedge clk);
    n_cmp++; if (fall_cnt - f0 != 4) begin n_bad++; $display("FAIL rr_falls got %0d want 4", fall_cnt - f0); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_busy_ignore();
    test_reset_mid_strobe();
    test_round_robin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
